clint_timer: RTL and testbench

Multi-hart machine timer peripheral: owns a free-running 64-bit `mtime` counter with programmable prescaler, one 64-bit `mtimecmp` compare register per hart, and registered per-hart timer-interrupt outputs. It sits on the shared 64-bit pipelined Wishbone data bus as a slave at a fixed base address. It replaces the external-register timer, which held no counter state, with a self-contained counter and compare block.

---
 rtl/clint_pkg.sv | 35 +++
 rtl/clint_prescaler.sv | 30 +++
 rtl/clint_timer.sv | 146 ++++++++++++++
 tb/tb_clint_timer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// Shared constants and helpers for the clint_timer register window.
// Build option: CLINT_MSIP_EN adds one MSIP register after the compare bank.
package clint_pkg;

  localparam logic [63:0] CLINT_OFF_MTIME    = 64'h00;
  localparam logic [63:0] CLINT_OFF_CTRL     = 64'h08;
  localparam logic [63:0] CLINT_OFF_CMP_BASE = 64'h10;

  localparam int CLINT_CTRL_EN_BIT  = 0;
  localparam int CLINT_CTRL_PRE_LSB = 16;
  localparam int CLINT_CTRL_PRE_MSB = 31;

`ifdef CLINT_MSIP_EN
  localparam bit CLINT_HAS_MSIP = 1'b1;
`else
  localparam bit CLINT_HAS_MSIP = 1'b0;
`endif

  function automatic logic [63:0] clint_win_size(input int nh);
    return CLINT_OFF_CMP_BASE + 64'(8 * nh) + (CLINT_HAS_MSIP ? 64'd8 : 64'd0);
  endfunction

  function automatic logic [63:0] clint_bmask(input logic [7:0] sel);
    logic [63:0] m;
    for (int b = 0; b < 8; b++) m[b*8 +: 8] = {8{sel[b]}};
    return m;
  endfunction

  function automatic logic [63:0] clint_merge(input logic [63:0] old_v,
                                              input logic [63:0] new_v,
                                              input logic [63:0] m);
    return (old_v & ~m) | (new_v & m);
  endfunction

endpackage

// File: rtl/clint_prescaler.sv
// Programmable 16-bit clock divider: one-cycle tick every prescale+1 enabled clocks.
module clint_prescaler (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_en,
  input  logic        i_clr,
  input  logic [15:0] i_prescale,
  output logic        o_tick
);

  logic [15:0] cnt_q, cnt_d;
  logic        tick;

  // >= rather than == so a counter left above a lowered limit still rolls over
  always_comb begin
    tick  = i_en && !i_clr && (cnt_q >= i_prescale);
    cnt_d = cnt_q;
    if (i_clr)     cnt_d = '0;
    else if (tick) cnt_d = '0;
    else if (i_en) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign o_tick = tick;

endmodule

// File: rtl/clint_timer.sv
// Multi-hart machine timer: prescaled 64-bit mtime, per-hart mtimecmp, Wishbone slave.
// Build option: CLINT_MSIP_EN adds the MSIP register and o_msip output.
import clint_pkg::*;

module clint_timer #(
  parameter logic [63:0] MAPPED_ADDRESS = 64'h1_0000_2000,
  parameter int          NUM_HARTS      = 1,
  parameter logic [15:0] RESET_PRESCALE = 16'd0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [63:0]          i_wb_adr,
  input  logic [63:0]          i_wb_dat,
  inout  wire  [63:0]          o_wb_dat,
  input  logic                 i_wb_we,
  input  logic [7:0]           i_wb_sel,
  input  logic                 i_wb_stb,
  inout  wire                  o_wb_ack,
  inout  wire                  o_wb_stall,
  input  logic                 i_wb_cyc,
`ifdef CLINT_MSIP_EN
  output logic [NUM_HARTS-1:0] o_msip,
`endif
  output logic [NUM_HARTS-1:0] o_mtip,
  output logic [63:0]          o_mtime
);

  localparam logic [63:0] WIN_SIZE = clint_win_size(NUM_HARTS);

  logic [63:0]                 mtime_q, mtime_d;
  logic                        en_q, en_d;
  logic [15:0]                 pre_q, pre_d;
  logic [NUM_HARTS-1:0][63:0]  cmp_q, cmp_d;
  logic [NUM_HARTS-1:0]        mtip_q, mtip_d;
  logic                        ack_q, ack_d;
  logic [63:0]                 rd_q, rd_d;

  logic [63:0] off, m, rd_val, ctrl_rd, ctrl_m;
  logic        match, accept, wr, ctrl_wr, tick;
  logic        unused_ctrl;

  assign off    = i_wb_adr - MAPPED_ADDRESS;
  assign match  = (i_wb_adr >= MAPPED_ADDRESS) && (off < WIN_SIZE);
  assign accept = match && i_wb_cyc && i_wb_stb;
  assign wr     = accept && i_wb_we;
  assign m      = clint_bmask(i_wb_sel);

`ifdef CLINT_MSIP_EN
  logic [NUM_HARTS-1:0] msip_q, msip_d;
  logic [63:0]          msip_m;
  logic                 unused_msip;
  localparam logic [63:0] MSIP_OFF = CLINT_OFF_CMP_BASE + 64'(8 * NUM_HARTS);

  always_comb begin
    msip_m = clint_merge(64'(msip_q), i_wb_dat, m);
    msip_d = msip_q;
    if (wr && off == MSIP_OFF) msip_d = msip_m[NUM_HARTS-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) msip_q <= '0;
    else         msip_q <= msip_d;
  end

  assign unused_msip = ^msip_m;
  assign o_msip      = msip_q;
`endif

  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CLINT_CTRL_EN_BIT] = en_q;
    ctrl_rd[CLINT_CTRL_PRE_MSB:CLINT_CTRL_PRE_LSB] = pre_q;

    // exact offset compares also reject unaligned addresses
    rd_val = '0;
    if (off == CLINT_OFF_MTIME) rd_val = mtime_q;
    if (off == CLINT_OFF_CTRL)  rd_val = ctrl_rd;
    for (int k = 0; k < NUM_HARTS; k++)
      if (off == CLINT_OFF_CMP_BASE + 64'(8 * k)) rd_val = cmp_q[k];
`ifdef CLINT_MSIP_EN
    if (off == MSIP_OFF) rd_val = 64'(msip_q);
`endif

    ctrl_wr = wr && (off == CLINT_OFF_CTRL);
    ctrl_m  = clint_merge(ctrl_rd, i_wb_dat, m);
    en_d    = en_q;
    pre_d   = pre_q;
    if (ctrl_wr) begin
      en_d  = ctrl_m[CLINT_CTRL_EN_BIT];
      pre_d = ctrl_m[CLINT_CTRL_PRE_MSB:CLINT_CTRL_PRE_LSB];
    end

    // a software write overrides a coincident tick
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    if (wr && off == CLINT_OFF_MTIME) mtime_d = clint_merge(mtime_q, i_wb_dat, m);

    cmp_d = cmp_q;
    for (int k = 0; k < NUM_HARTS; k++) begin
      if (wr && off == CLINT_OFF_CMP_BASE + 64'(8 * k))
        cmp_d[k] = clint_merge(cmp_q[k], i_wb_dat, m);
      mtip_d[k] = (mtime_q >= cmp_q[k]);
    end

    ack_d = accept;
    rd_d  = (accept && !i_wb_we) ? (rd_val & m) : rd_q;
  end

  assign unused_ctrl = ^{ctrl_m[63:CLINT_CTRL_PRE_MSB+1],
                         ctrl_m[CLINT_CTRL_PRE_LSB-1:CLINT_CTRL_EN_BIT+1]};

  clint_prescaler u_pre (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_en       (en_q),
    .i_clr      (ctrl_wr),
    .i_prescale (pre_q),
    .o_tick     (tick)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mtime_q <= '0;
      en_q    <= 1'b1;
      pre_q   <= RESET_PRESCALE;
      cmp_q   <= '1;
      mtip_q  <= '0;
      ack_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      mtime_q <= mtime_d;
      en_q    <= en_d;
      pre_q   <= pre_d;
      cmp_q   <= cmp_d;
      mtip_q  <= mtip_d;
      ack_q   <= ack_d;
      rd_q    <= rd_d;
    end
  end

  assign o_wb_dat   = match ? rd_q : {64{1'bz}};
  assign o_wb_ack   = match ? ack_q : 1'bz;
  assign o_wb_stall = accept ? 1'b0 : 1'bz;
  assign o_mtip     = mtip_q;
  assign o_mtime    = mtime_q;

endmodule

// File: tb/tb_clint_timer.sv
// Directed self-checking bench for clint_timer with two harts (default build).
module tb_clint_timer;

  localparam logic [63:0] BASE = 64'h1_0000_2000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] adr, wdat;
  logic        we, stb, cyc;
  logic [7:0]  sel;
  tri1  [63:0] dat_w;
  tri1         ack_w, stall_w;
  logic [1:0]  mtip;
  logic [63:0] mtime;
`ifdef CLINT_MSIP_EN
  logic [1:0]  msip;
`endif

  int total = 0;
  int bad   = 0;
  logic [63:0] a, b, r;

  clint_timer #(.MAPPED_ADDRESS(BASE), .NUM_HARTS(2), .RESET_PRESCALE(16'd0)) dut (
    .i_clk(clk), .i_reset(rst), .i_wb_adr(adr), .i_wb_dat(wdat), .o_wb_dat(dat_w),
    .i_wb_we(we), .i_wb_sel(sel), .i_wb_stb(stb), .o_wb_ack(ack_w),
    .o_wb_stall(stall_w), .i_wb_cyc(cyc),
`ifdef CLINT_MSIP_EN
    .o_msip(msip),
`endif
    .o_mtip(mtip), .o_mtime(mtime)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one-cycle request at a negedge; returns at the negedge of the ack cycle
  task automatic acc(input logic w, input logic [63:0] off, input logic [63:0] d,
                     input logic [7:0] s, output logic [63:0] rdata);
    adr = BASE + off; wdat = d; we = w; sel = s; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("ack", 64'(ack_w), 64'd1);
    rdata = dat_w;
  endtask

  task automatic wr(input logic [63:0] off, input logic [63:0] d, input logic [7:0] s);
    logic [63:0] dummy;
    acc(1'b1, off, d, s, dummy);
  endtask

  task automatic rd(input logic [63:0] off, input logic [7:0] s, output logic [63:0] v);
    acc(1'b0, off, 64'd0, s, v);
  endtask

  initial begin
    rst = 1'b1; adr = BASE; wdat = '0; we = 1'b0; stb = 1'b0; cyc = 1'b0; sel = 8'hFF;
    repeat (3) @(negedge clk);
    chk("rst_mtime", mtime, 64'd0);
    chk("rst_mtip", 64'(mtip), 64'd0);
    chk("rst_ack", 64'(ack_w), 64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("mtime_out5", mtime, 64'd5);
    rd(64'h00, 8'hFF, r); chk("mtime_rd5", r, 64'd5);
    rd(64'h10, 8'hFF, r); chk("cmp0_rst", r, ONES);
    rd(64'h18, 8'hFF, r); chk("cmp1_rst", r, ONES);
    rd(64'h08, 8'hFF, r); chk("ctrl_rst", r, 64'h1);
    chk("mtip_idle", 64'(mtip), 64'd0);

    // prescale 3: one tick per 4 clocks
    wr(64'h08, 64'h3_0001, 8'hFF);
    rd(64'h08, 8'hFF, r); chk("ctrl_pre3", r, 64'h3_0001);
    rd(64'h00, 8'hFF, a);
    repeat (39) @(negedge clk);
    rd(64'h00, 8'hFF, b);
    chk("presc_delta", b - a, 64'd10);

    // compare on hart 1
    wr(64'h08, 64'h1, 8'hFF);
    wr(64'h00, 64'd1000, 8'hFF);
    wr(64'h18, 64'd1021, 8'hFF);
    repeat (20) @(negedge clk);
    chk("mtip_before", 64'(mtip), 64'd0);
    @(negedge clk);
    chk("mtip1_rise", 64'(mtip), 64'b10);
    wr(64'h18, ONES, 8'hFF);
    chk("mtip1_hold", 64'(mtip), 64'b10);
    @(negedge clk);
    chk("mtip1_fall", 64'(mtip), 64'd0);

    // wrap and write-vs-tick
    wr(64'h00, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
    @(negedge clk);
    rd(64'h00, 8'hFF, r); chk("wrap_ff", r, ONES);
    chk("wrap_out0", mtime, 64'd0);
    rd(64'h00, 8'hFF, r); chk("wrap_0", r, 64'd0);
    wr(64'h00, 64'd500, 8'hFF);
    rd(64'h00, 8'hFF, r); chk("wr_wins", r, 64'd500);

    // byte lanes
    wr(64'h10, 64'h1122_3344_5566_7788, 8'h0F);
    rd(64'h10, 8'hFF, r); chk("bytewr", r, 64'hFFFF_FFFF_5566_7788);
    rd(64'h10, 8'hF0, r); chk("bytemask", r, 64'hFFFF_FFFF_0000_0000);

    // unaligned offset: acked, ignored, reads zero
    wr(64'h0C, ONES, 8'hFF);
    rd(64'h0C, 8'hFF, r); chk("unal_rd", r, 64'd0);
    rd(64'h08, 8'hFF, r); chk("unal_ctrl", r, 64'h1);

    // back-to-back reads
    adr = BASE + 64'h18; we = 1'b0; sel = 8'hFF; cyc = 1'b1; stb = 1'b1;
    #1 chk("stall0", 64'(stall_w), 64'd0);
    @(negedge clk);
    chk("b2b_ack1", 64'(ack_w), 64'd1); chk("b2b_d1", dat_w, ONES);
    adr = BASE + 64'h10;
    @(negedge clk);
    chk("b2b_ack2", 64'(ack_w), 64'd1); chk("b2b_d2", dat_w, 64'hFFFF_FFFF_5566_7788);
    adr = BASE + 64'h08;
    @(negedge clk);
    chk("b2b_ack3", 64'(ack_w), 64'd1); chk("b2b_d3", dat_w, 64'h1);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk("b2b_idle", 64'(ack_w), 64'd0);

    // outside window: bus left undriven (pulled high)
    adr = BASE + 64'h20; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    chk("oow_ack", 64'(ack_w), 64'd1);
    chk("oow_dat", dat_w, ONES);
    chk("oow_stall", 64'(stall_w), 64'd1);
    adr = BASE - 64'h8;
    @(negedge clk);
    chk("below_ack", 64'(ack_w), 64'd1);
    cyc = 1'b0; stb = 1'b0;

    // reset during a request drops its ack and restores state
    wr(64'h10, 64'd0, 8'hFF);
    @(negedge clk);
    chk("mtip0_set", 64'(mtip), 64'b01);
    adr = BASE; we = 1'b0; cyc = 1'b1; stb = 1'b1; rst = 1'b1;
    @(negedge clk);
    chk("rst_noack", 64'(ack_w), 64'd0);
    chk("rst2_mtime", mtime, 64'd0);
    chk("rst2_mtip", 64'(mtip), 64'd0);
    cyc = 1'b0; stb = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("rst2_noack", 64'(ack_w), 64'd0);
    rd(64'h10, 8'hFF, r); chk("rst2_cmp0", r, ONES);
    rd(64'h08, 8'hFF, r); chk("rst2_ctrl", r, 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
